// File: rtl/zxbus_pkg.sv
// Shared types and default bus timing for the ZX-bus I/O host.
package zxbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    localparam int unsigned DEF_T_SETUP   = 2;
    localparam int unsigned DEF_T_ACTIVE  = 8;
    localparam int unsigned DEF_T_HOLD    = 2;
    localparam int unsigned DEF_T_RECOVER = 2;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/zxbus_host_if.sv
// Request/completion handshake between a client and the ZX-bus I/O host.
interface zxbus_host_if;

    logic       req;
    logic       req_ready;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       done;
    logic [7:0] rdata;
    logic       claimed;

    modport master (
        output req, req_wr, req_addr, req_wdata,
        input  req_ready, done, rdata, claimed
    );

    modport slave (
        input  req, req_wr, req_addr, req_wdata,
        output req_ready, done, rdata, claimed
    );

endinterface

// File: rtl/zxbus_host.sv
// ZX-bus I/O cycle generator: one request in, one timed IORQ read/write cycle out.
// All bus strobes and the data-bus enable are registered so they cannot glitch.
module zxbus_host
    import zxbus_pkg::*;
#(
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_ACTIVE  = DEF_T_ACTIVE,
    parameter int unsigned T_HOLD    = DEF_T_HOLD,
    parameter int unsigned T_RECOVER = DEF_T_RECOVER
) (
    input  logic              clk,
    input  logic              rst,
    zxbus_host_if.slave       cmd,
    output logic [7:0]        zxa,
    inout  tri   [7:0]        zxid,
    output logic              zxiorq_n,
    output logic              zxrd_n,
    output logic              zxwr_n,
    output logic              zxmreq_n,
    input  logic              zxblkiorq_n
);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_load;
    logic               last;

    logic               accept;
    logic               capture;
    logic               dir_nx;
    logic               iorq_nx;
    logic               rd_nx;
    logic               wr_nx;
    logic               oe_nx;
    logic               done_nx;

    logic               wr_q;
    logic [7:0]         wdata_q;
    logic               zxid_oe;
    logic [7:0]         rdata_q;
    logic               claimed_q;
    logic               done_q;

    assign last    = (cnt == '0);
    assign accept  = (state == ST_IDLE) && cmd.req;
    assign capture = (state == ST_ACTIVE) && last;

    // State register and phase down-counter, reloaded whenever the state changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state)
                cnt <= cnt_load;
            else if (state == ST_IDLE)
                cnt <= '0;
            else
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (cmd.req) state_nx = ST_SETUP;
            ST_SETUP:   if (last)    state_nx = ST_ACTIVE;
            ST_ACTIVE:  if (last)    state_nx = ST_HOLD;
            ST_HOLD:    if (last)    state_nx = ST_RECOVER;
            ST_RECOVER: if (last)    state_nx = ST_IDLE;
            default:                 state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_load = '0;
        unique case (state_nx)
            ST_SETUP:   cnt_load = CNT_W'(T_SETUP - 1);
            ST_ACTIVE:  cnt_load = CNT_W'(T_ACTIVE - 1);
            ST_HOLD:    cnt_load = CNT_W'(T_HOLD - 1);
            ST_RECOVER: cnt_load = CNT_W'(T_RECOVER - 1);
            default:    cnt_load = '0;
        endcase
    end

    // Output decode works on the next state so the registered strobes line up with the state.
    always_comb begin
        dir_nx  = accept ? cmd.req_wr : wr_q;
        iorq_nx = 1'b1;
        rd_nx   = 1'b1;
        wr_nx   = 1'b1;
        oe_nx   = 1'b0;
        done_nx = (state == ST_HOLD) && (state_nx == ST_RECOVER);
        if (state_nx == ST_ACTIVE) begin
            iorq_nx = 1'b0;
            rd_nx   = dir_nx;
            wr_nx   = !dir_nx;
        end
        if ((state_nx == ST_SETUP) || (state_nx == ST_ACTIVE) || (state_nx == ST_HOLD))
            oe_nx = dir_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zxiorq_n <= 1'b1;
            zxrd_n   <= 1'b1;
            zxwr_n   <= 1'b1;
            zxid_oe  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            zxiorq_n <= iorq_nx;
            zxrd_n   <= rd_nx;
            zxwr_n   <= wr_nx;
            zxid_oe  <= oe_nx;
            done_q   <= done_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zxa       <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rdata_q   <= '0;
            claimed_q <= 1'b0;
        end else begin
            if (accept) begin
                zxa     <= cmd.req_addr;
                wdata_q <= cmd.req_wdata;
                wr_q    <= cmd.req_wr;
            end
            if (capture) begin
                if (!wr_q)
                    rdata_q <= zxid;
                claimed_q <= !zxblkiorq_n;
            end
        end
    end

    assign zxid          = zxid_oe ? wdata_q : 'z;
    assign zxmreq_n      = 1'b1;
    assign cmd.req_ready = (state == ST_IDLE);
    assign cmd.done      = done_q;
    assign cmd.rdata     = rdata_q;
    assign cmd.claimed   = claimed_q;

endmodule

// File: tb/tb_zxbus_host.sv
// Directed bench for zxbus_host with a small ZX-bus device model on the far side.
module tb_zxbus_host;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] zxa;
    tri   [7:0] zxid;
    logic       zxiorq_n, zxrd_n, zxwr_n, zxmreq_n;
    logic       zxblkiorq_n;

    zxbus_host_if cif ();

    zxbus_host #(
        .T_SETUP   (2),
        .T_ACTIVE  (8),
        .T_HOLD    (2),
        .T_RECOVER (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cif.slave),
        .zxa         (zxa),
        .zxid        (zxid),
        .zxiorq_n    (zxiorq_n),
        .zxrd_n      (zxrd_n),
        .zxwr_n      (zxwr_n),
        .zxmreq_n    (zxmreq_n),
        .zxblkiorq_n (zxblkiorq_n)
    );

    always #5 clk = ~clk;

    // Device model: 0xBB returns 0x5A, 0x3B is a test register read back inverted,
    // anything else is unclaimed and reads as the pulled-up bus value 0xFF.
    logic [7:0] dev_reg = 8'h00;
    logic [7:0] dev_rd;
    always_comb begin
        dev_rd = 8'hFF;
        if (zxa == 8'hBB)      dev_rd = 8'h5A;
        else if (zxa == 8'h3B) dev_rd = ~dev_reg;
    end
    assign zxid        = (!zxiorq_n && !zxrd_n) ? dev_rd : 8'hzz;
    assign zxblkiorq_n = !(!zxiorq_n && ((zxa == 8'hBB) || (zxa == 8'h3B)));

    always @(posedge clk)
        if (!zxiorq_n && !zxwr_n && (zxa == 8'h3B))
            dev_reg <= zxid;

    int tests = 0;
    int fails = 0;

    int n_wr_low, n_rd_low, n_iorq_low, n_both_low, first_iorq_k;
    int done_k, n_done, n_ready_busy, n_bad_data, ready_end;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full request from IDLE; samples 15 clocks starting at the accept edge.
    task automatic run_cycle(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        n_wr_low = 0; n_rd_low = 0; n_iorq_low = 0; n_both_low = 0; first_iorq_k = -1;
        done_k = -1; n_done = 0; n_ready_busy = 0; n_bad_data = 0; ready_end = 0;
        cif.req       = 1'b1;
        cif.req_wr    = wr;
        cif.req_addr  = addr;
        cif.req_wdata = wdata;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k == 0) cif.req = 1'b0;
            if (!zxwr_n) n_wr_low++;
            if (!zxrd_n) n_rd_low++;
            if (!zxwr_n && !zxrd_n) n_both_low++;
            if (!zxiorq_n) begin
                n_iorq_low++;
                if (first_iorq_k < 0) first_iorq_k = k;
            end
            if (cif.done) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (k < 14 && cif.req_ready) n_ready_busy++;
            if (wr && k <= 11) begin
                if (dut.zxid_oe !== 1'b1 || zxid !== wdata) n_bad_data++;
            end else if (dut.zxid_oe !== 1'b0) begin
                n_bad_data++;
            end
            if (k == 14) ready_end = int'(cif.req_ready);
        end
    endtask

    task automatic check_cycle(input string tag, input logic wr);
        chk({tag, ".wr_low"},     n_wr_low,     wr ? 8 : 0);
        chk({tag, ".rd_low"},     n_rd_low,     wr ? 0 : 8);
        chk({tag, ".iorq_low"},   n_iorq_low,   8);
        chk({tag, ".both_low"},   n_both_low,   0);
        chk({tag, ".iorq_start"}, first_iorq_k, 2);
        chk({tag, ".done_at"},    done_k,       12);
        chk({tag, ".done_cnt"},   n_done,       1);
        chk({tag, ".ready_busy"}, n_ready_busy, 0);
        chk({tag, ".data_bus"},   n_bad_data,   0);
        chk({tag, ".ready_end"},  ready_end,    1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d1, d2, d3, nd, n_iorq_fall, prev_iorq;

        cif.req = 1'b0; cif.req_wr = 1'b0; cif.req_addr = 8'h00; cif.req_wdata = 8'h00;
        tick();
        tick();
        chk("rst.iorq",    int'(zxiorq_n),    1);
        chk("rst.rd",      int'(zxrd_n),      1);
        chk("rst.wr",      int'(zxwr_n),      1);
        chk("rst.mreq",    int'(zxmreq_n),    1);
        chk("rst.oe",      int'(dut.zxid_oe), 0);
        chk("rst.zxa",     int'(zxa),         0);
        chk("rst.rdata",   int'(cif.rdata),   0);
        chk("rst.claimed", int'(cif.claimed), 0);
        chk("rst.done",    int'(cif.done),    0);
        rst = 1'b0;
        tick();
        chk("rst.ready", int'(cif.req_ready), 1);

        run_cycle(1'b1, 8'h33, 8'h80);
        check_cycle("wr33", 1'b1);
        chk("wr33.zxa_kept", int'(zxa),         8'h33);
        chk("wr33.claimed",  int'(cif.claimed), 0);

        run_cycle(1'b0, 8'hBB, 8'h00);
        check_cycle("rdBB", 1'b0);
        chk("rdBB.rdata",   int'(cif.rdata),   8'h5A);
        chk("rdBB.claimed", int'(cif.claimed), 1);

        run_cycle(1'b0, 8'h10, 8'h00);
        check_cycle("rd10", 1'b0);
        chk("rd10.rdata",   int'(cif.rdata),   8'hFF);
        chk("rd10.claimed", int'(cif.claimed), 0);

        run_cycle(1'b1, 8'h3B, 8'hA5);
        check_cycle("wr3B_1", 1'b1);
        chk("wr3B_1.rdata_kept", int'(cif.rdata),   8'hFF);
        chk("wr3B_1.claimed",    int'(cif.claimed), 1);
        run_cycle(1'b1, 8'h3B, 8'hA5);
        chk("wr3B_2.done_at", done_k,  12);
        chk("wr3B_2.devreg",  int'(dev_reg), 8'hA5);
        run_cycle(1'b0, 8'h3B, 8'h00);
        check_cycle("rd3B", 1'b0);
        chk("rd3B.rdata",   int'(cif.rdata),   8'h5A);
        chk("rd3B.claimed", int'(cif.claimed), 1);

        // Request held high: cycles must start 15 clocks apart with nothing extra.
        d1 = -1; d2 = -1; d3 = -1; nd = 0; n_iorq_fall = 0; prev_iorq = 1;
        cif.req = 1'b1; cif.req_wr = 1'b0; cif.req_addr = 8'h10;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (cif.done) begin
                nd++;
                if (nd == 1) d1 = k;
                if (nd == 2) d2 = k;
                if (nd == 3) d3 = k;
            end
            if (prev_iorq == 1 && zxiorq_n == 1'b0) n_iorq_fall++;
            prev_iorq = int'(zxiorq_n);
        end
        cif.req = 1'b0;
        chk("b2b.done_cnt",  nd,          3);
        chk("b2b.first",     d1,          12);
        chk("b2b.gap1",      d2 - d1,     15);
        chk("b2b.gap2",      d3 - d2,     15);
        chk("b2b.iorq_cnt",  n_iorq_fall, 3);

        // Reset in the middle of a write's ACTIVE phase.
        cif.req = 1'b1; cif.req_wr = 1'b1; cif.req_addr = 8'h33; cif.req_wdata = 8'h77;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) cif.req = 1'b0;
        end
        chk("abort.pre_wr", int'(zxwr_n), 0);
        #1 rst = 1'b1;
        #1;
        chk("abort.wr",   int'(zxwr_n),      1);
        chk("abort.iorq", int'(zxiorq_n),    1);
        chk("abort.rd",   int'(zxrd_n),      1);
        chk("abort.oe",   int'(dut.zxid_oe), 0);
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (cif.done) nd++;
        end
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (cif.done) nd++;
        end
        chk("abort.no_done", nd,                 0);
        chk("abort.ready",   int'(cif.req_ready), 1);
        chk("abort.rdata",   int'(cif.rdata),     0);
        chk("abort.claimed", int'(cif.claimed),   0);
        chk("abort.zxa",     int'(zxa),           0);

        run_cycle(1'b0, 8'hBB, 8'h00);
        check_cycle("post", 1'b0);
        chk("post.rdata",   int'(cif.rdata),   8'h5A);
        chk("post.claimed", int'(cif.claimed), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
